// File: rtl/rk_crt_pkg.sv
// ============================================================================
// rk_crt_pkg : shared constants and state encodings for the CRT row sequencer
// Revision    : 1.0
// ============================================================================
`default_nettype none

package rk_crt_pkg;

   localparam int RK_MAX_COLS = 80;

   localparam logic [2:0] REG_CPR     = 3'd0;
   localparam logic [2:0] REG_RPS     = 3'd1;
   localparam logic [2:0] REG_LPR     = 3'd2;
   localparam logic [2:0] REG_UL      = 3'd3;
   localparam logic [2:0] REG_CUR_COL = 3'd4;
   localparam logic [2:0] REG_CUR_ROW = 3'd5;
   localparam logic [2:0] REG_CTRL    = 3'd6;

   localparam logic [6:0] DEF_CPR = 7'd77;
   localparam logic [5:0] DEF_RPS = 6'd29;
   localparam logic [3:0] DEF_LPR = 4'd9;
   localparam logic [3:0] DEF_UL  = 4'd9;

   typedef enum logic [1:0] {
      F_IDLE = 2'd0,
      F_FILL = 2'd1,
      F_DONE = 2'd2
   } fetch_state_t;

   typedef enum logic [1:0] {
      D_END    = 2'd0,
      D_PRIME  = 2'd1,
      D_ACTIVE = 2'd2
   } disp_state_t;

endpackage

`default_nettype wire

// File: rtl/rk_row_buffer.sv
// ============================================================================
// rk_row_buffer : two-bank character row RAM, DMA write port, display read port
// Revision      : 1.0
// ============================================================================
`default_nettype none

module rk_row_buffer #(
   parameter int DEPTH = 80,
   parameter int AW    = 7
) (
   input  logic          clk,
   input  logic          we,
   input  logic          wbank,
   input  logic [AW-1:0] waddr,
   input  logic [6:0]    wdata,
   input  logic          rbank,
   input  logic [AW-1:0] raddr,
   output logic [6:0]    rdata
);

   logic [6:0] mem [2][DEPTH];

   always_ff @(posedge clk) begin
      if (we) mem[wbank][waddr] <= wdata;
   end

   assign rdata = mem[rbank][raddr];

endmodule

`default_nettype wire

// File: rtl/rk_crt_ctrl.sv
// ============================================================================
// rk_crt_ctrl : 8275-style row scheduler; DMA row fetch into ping-pong buffers
//               and per-character-clock video attribute generation
// Revision    : 1.0
// ============================================================================
`default_nettype none

module rk_crt_ctrl
   import rk_crt_pkg::*;
#(
   parameter int MAX_COLS  = RK_MAX_COLS,
   parameter int BLINK_BIT = 4
) (
   input  logic       clk50mhz,
   input  logic       reset,
   input  logic       cfg_we,
   input  logic [2:0] cfg_addr,
   input  logic [7:0] cfg_data,
   input  logic       cce,
   input  logic       line_end,
   input  logic       frame_end,
   output logic       dreq,
   input  logic       dack,
   input  logic [7:0] ddata,
   output logic [6:0] ichar,
   output logic [3:0] line,
   output logic       vsp,
   output logic       lten,
   output logic       rvv,
   output logic       frame_irq,
   output logic       underrun
);

   localparam int         FCW       = BLINK_BIT + 1;
   localparam logic [6:0] CPR_LIMIT = 7'(MAX_COLS - 1);

   logic [6:0] cpr, cur_col;
   logic [5:0] rps, cur_row;
   logic [3:0] lpr, ul;
   logic [2:0] ctrl;

   fetch_state_t fstate, fstate_n;
   logic         fbank, fbank_n;
   logic [6:0]   count, count_n;
   logic         start, start_bank, wr_en, fetch_done;

   disp_state_t    dstate, dstate_n;
   logic [5:0]     row, row_n;
   logic [3:0]     line_n;
   logic [6:0]     col, col_n, rd_addr;
   logic [6:0]     rd_data;
   logic           disp_bank, disp_bank_n, row_blank, row_blank_n;
   logic [FCW-1:0] frame_cnt, frame_cnt_n;
   logic           irq_n, set_ur, blank, cursor_hit;
   logic           unused_bits;

   assign unused_bits = ddata[7] ^ cfg_data[7];

   always_ff @(posedge clk50mhz or posedge reset) begin
      if (reset) begin
         cpr      <= DEF_CPR;
         rps      <= DEF_RPS;
         lpr      <= DEF_LPR;
         ul       <= DEF_UL;
         cur_col  <= '0;
         cur_row  <= '0;
         ctrl     <= '0;
         underrun <= 1'b0;
      end else begin
         if (cfg_we) begin
            case (cfg_addr)
               REG_CPR:     cpr     <= (cfg_data[6:0] > CPR_LIMIT) ? CPR_LIMIT : cfg_data[6:0];
               REG_RPS:     rps     <= cfg_data[5:0];
               REG_LPR:     lpr     <= cfg_data[3:0];
               REG_UL:      ul      <= cfg_data[3:0];
               REG_CUR_COL: cur_col <= cfg_data[6:0];
               REG_CUR_ROW: cur_row <= cfg_data[5:0];
               REG_CTRL:    ctrl    <= cfg_data[2:0];
               default: ;
            endcase
         end
         if (cfg_we && cfg_addr == REG_CTRL) underrun <= 1'b0;
         // A new underrun in the same clock as a ctrl write must not be lost.
         if (set_ur) underrun <= 1'b1;
      end
   end

   // ---------------- fetch FSM ----------------
   always_comb begin
      fstate_n = fstate;
      fbank_n  = fbank;
      count_n  = count;
      if (start) begin
         fstate_n = F_FILL;
         fbank_n  = start_bank;
         count_n  = '0;
      end else if (fstate == F_FILL && dack) begin
         count_n = count + 7'd1;
         // >= so a cpr lowered below the current count still terminates the fill
         if (count >= cpr) fstate_n = F_DONE;
      end
   end

   always_ff @(posedge clk50mhz or posedge reset) begin
      if (reset) begin
         fstate <= F_IDLE;
         fbank  <= 1'b0;
         count  <= '0;
         dreq   <= 1'b0;
      end else begin
         fstate <= fstate_n;
         fbank  <= fbank_n;
         count  <= count_n;
         dreq   <= (fstate_n == F_FILL);
      end
   end

   assign wr_en      = (fstate == F_FILL) && dack;
   assign fetch_done = (fstate == F_DONE);

   // ---------------- display FSM ----------------
   always_comb begin
      dstate_n    = dstate;
      row_n       = row;
      line_n      = line;
      col_n       = col;
      disp_bank_n = disp_bank;
      row_blank_n = row_blank;
      frame_cnt_n = frame_cnt;
      irq_n       = 1'b0;
      set_ur      = 1'b0;
      start       = 1'b0;
      start_bank  = 1'b0;
      if (cce && col <= cpr) col_n = col + 7'd1;
      if (frame_end) begin
         row_n       = '0;
         line_n      = '0;
         col_n       = '0;
         row_blank_n = 1'b0;
         frame_cnt_n = frame_cnt + FCW'(1);
         irq_n       = 1'b1;
         if (ctrl[0]) begin
            start    = 1'b1;
            dstate_n = D_PRIME;
         end else begin
            dstate_n = D_END;
         end
      end else if (line_end) begin
         col_n = '0;
         case (dstate)
            D_PRIME: begin
               if (fetch_done) begin
                  disp_bank_n = 1'b0;
                  line_n      = '0;
                  dstate_n    = D_ACTIVE;
                  if (rps != 6'd0) begin
                     start      = 1'b1;
                     start_bank = 1'b1;
                  end
               end
            end
            D_ACTIVE: begin
               if (line < lpr) begin
                  line_n = line + 4'd1;
               end else if (row >= rps) begin
                  dstate_n = D_END;
               end else begin
                  row_n  = row + 6'd1;
                  line_n = '0;
                  if (fetch_done) begin
                     disp_bank_n = ~disp_bank;
                     row_blank_n = 1'b0;
                     if (({1'b0, row} + 7'd1) < {1'b0, rps}) begin
                        start      = 1'b1;
                        start_bank = ~disp_bank;
                     end
                  end else begin
                     set_ur      = 1'b1;
                     row_blank_n = 1'b1;
                     start       = 1'b1;
                     start_bank  = fbank;
                  end
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk50mhz or posedge reset) begin
      if (reset) begin
         dstate    <= D_END;
         row       <= '0;
         line      <= '0;
         col       <= '0;
         disp_bank <= 1'b0;
         row_blank <= 1'b0;
         frame_cnt <= '0;
         frame_irq <= 1'b0;
      end else begin
         dstate    <= dstate_n;
         row       <= row_n;
         line      <= line_n;
         col       <= col_n;
         disp_bank <= disp_bank_n;
         row_blank <= row_blank_n;
         frame_cnt <= frame_cnt_n;
         frame_irq <= irq_n;
      end
   end

   // Past the last column the read address is parked to stay inside the bank.
   assign rd_addr    = (col > cpr) ? 7'd0 : col;
   assign blank      = (dstate != D_ACTIVE) || !ctrl[0] || (col > cpr) || row_blank;
   assign cursor_hit = (col == cur_col) && (row == cur_row) && (line == ul) &&
                       (dstate == D_ACTIVE) && (!ctrl[2] || !frame_cnt[BLINK_BIT]);

   always_ff @(posedge clk50mhz or posedge reset) begin
      if (reset) begin
         ichar <= '0;
         vsp   <= 1'b1;
         lten  <= 1'b0;
         rvv   <= 1'b0;
      end else if (cce) begin
         ichar <= blank ? 7'd0 : rd_data;
         vsp   <= blank;
         lten  <= cursor_hit;
         rvv   <= ctrl[1];
      end
   end

   rk_row_buffer #(
      .DEPTH (MAX_COLS),
      .AW    (7)
   ) u_row_buffer (
      .clk   (clk50mhz),
      .we    (wr_en),
      .wbank (fbank),
      .waddr (count),
      .wdata (ddata[6:0]),
      .rbank (disp_bank),
      .raddr (rd_addr),
      .rdata (rd_data)
   );

endmodule

`default_nettype wire

// File: tb/tb_rk_crt_ctrl.sv
// ============================================================================
// tb_rk_crt_ctrl : scenario bench for rk_crt_ctrl with DMA-data scoreboard
// Revision       : 1.0
// ============================================================================
`default_nettype none

module tb_rk_crt_ctrl;

   logic       clk50mhz = 1'b0;
   logic       reset = 1'b1;
   logic       cfg_we = 1'b0;
   logic [2:0] cfg_addr = 3'd0;
   logic [7:0] cfg_data = 8'd0;
   logic       cce = 1'b0, line_end = 1'b0, frame_end = 1'b0, dack = 1'b0;
   logic [7:0] ddata = 8'd0;
   logic       dreq, vsp, lten, rvv, frame_irq, underrun;
   logic [6:0] ichar;
   logic [3:0] line;

   int         errors = 0;
   int         checks = 0;
   logic [6:0] sb_q[$];

   rk_crt_ctrl #(.MAX_COLS(80), .BLINK_BIT(4)) dut (
      .clk50mhz (clk50mhz), .reset (reset),
      .cfg_we (cfg_we), .cfg_addr (cfg_addr), .cfg_data (cfg_data),
      .cce (cce), .line_end (line_end), .frame_end (frame_end),
      .dreq (dreq), .dack (dack), .ddata (ddata),
      .ichar (ichar), .line (line), .vsp (vsp), .lten (lten), .rvv (rvv),
      .frame_irq (frame_irq), .underrun (underrun)
   );

   always #10 clk50mhz = ~clk50mhz;

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not complete in time");
      $fatal(1);
   end

   task automatic tick();
      @(posedge clk50mhz);
      #1;
   endtask

   task automatic cfg_write(input logic [2:0] a, input logic [7:0] d);
      cfg_we = 1'b1; cfg_addr = a; cfg_data = d;
      tick();
      cfg_we = 1'b0;
   endtask

   task automatic pulse_frame_end();
      frame_end = 1'b1; tick(); frame_end = 1'b0;
   endtask

   task automatic pulse_line_end();
      line_end = 1'b1; tick(); line_end = 1'b0;
   endtask

   // Serves one DMA row; every accepted byte is queued as an expected character.
   task automatic dma_fill(input bit toggle, input logic [6:0] base, output int n);
      logic x;
      n = 0;
      for (int c = 0; c < 400; c++) begin
         if (n > 0 && !dreq) break;
         dack  = toggle ? (c % 2 == 0) : 1'b1;
         ddata = {1'b1, base + 7'(n)};
         x     = dreq & dack;
         tick();
         if (x) begin
            sb_q.push_back(base + 7'(n));
            n++;
         end
      end
      dack = 1'b0;
   endtask

   task automatic reset_dut();
      reset = 1'b1; tick(); tick(); reset = 1'b0; tick();
      sb_q.delete();
   endtask

   task automatic setup_small(input logic [7:0] ctrl_val);
      reset_dut();
      cfg_write(3'd0, 8'd3);
      cfg_write(3'd1, 8'd1);
      cfg_write(3'd2, 8'd1);
      cfg_write(3'd6, ctrl_val);
   endtask

   task automatic test_reset();
      int n;
      setup_small(8'h03);
      pulse_frame_end();
      dma_fill(1'b0, 7'h41, n);
      pulse_line_end();
      cce = 1'b1; tick(); cce = 1'b0;
      checks++;
      if ({dreq, vsp, ichar, rvv} !== {1'b1, 1'b0, 7'h41, 1'b1}) begin
         errors++;
         $display("FAIL pre_reset: dreq/vsp/ichar/rvv got %b/%b/%h/%b want 1/0/41/1", dreq, vsp, ichar, rvv);
      end
      #3 reset = 1'b1;
      #1;
      checks++;
      if ({dreq, vsp, ichar, lten, rvv, underrun, frame_irq, line} !== {1'b0, 1'b1, 7'h0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0}) begin
         errors++;
         $display("FAIL reset_async: dreq=%b vsp=%b ichar=%h lten=%b rvv=%b ur=%b irq=%b line=%0d want 0 1 00 0 0 0 0 0",
                  dreq, vsp, ichar, lten, rvv, underrun, frame_irq, line);
      end
      dack = 1'b1;
      tick(); tick();
      checks++;
      if ({dreq, vsp, ichar} !== {1'b0, 1'b1, 7'h0}) begin
         errors++;
         $display("FAIL reset_held: dreq=%b vsp=%b ichar=%h want 0 1 00", dreq, vsp, ichar);
      end
      dack = 1'b0;
      reset = 1'b0;
      tick();
      sb_q.delete();
   endtask

   task automatic test_default_dims();
      int n, rows;
      cfg_write(3'd6, 8'h01);
      pulse_frame_end();
      dma_fill(1'b0, 7'h20, n);
      checks++;
      if (n !== 78) begin
         errors++;
         $display("FAIL default_cols: transfers got %0d want 78", n);
      end
      pulse_line_end();
      rows = 0;
      for (int r = 0; r < 40; r++) begin
         cce = 1'b1; tick(); cce = 1'b0;
         if (vsp) break;
         rows++;
         if (dreq) dma_fill(1'b0, 7'h20, n);
         repeat (10) pulse_line_end();
      end
      checks++;
      if (rows !== 30) begin
         errors++;
         $display("FAIL default_rows: rows displayed got %0d want 30", rows);
      end
      checks++;
      if (underrun !== 1'b0) begin
         errors++;
         $display("FAIL default_underrun: got %b want 0", underrun);
      end
      sb_q.delete();
   endtask

   task automatic test_fill_display(input bit toggle, input logic [6:0] base);
      int n;
      logic bad;
      logic [6:0] exp_c;
      logic exp_v;
      setup_small(8'h01);
      pulse_frame_end();
      checks++;
      if ({frame_irq, dreq} !== 2'b11) begin
         errors++;
         $display("FAIL fill_start: irq/dreq got %b%b want 11", frame_irq, dreq);
      end
      dma_fill(toggle, base, n);
      checks++;
      if (n !== 4) begin
         errors++;
         $display("FAIL fill_count(toggle=%0d): transfers got %0d want 4", toggle, n);
      end
      bad = 1'b0;
      dack = 1'b1;
      repeat (4) begin
         tick();
         if (dreq !== 1'b0) bad = 1'b1;
      end
      dack = 1'b0;
      checks++;
      if (bad !== 1'b0) begin
         errors++;
         $display("FAIL fill_no_extra_req: dreq seen high got %b want 0", bad);
      end
      pulse_line_end();
      cce = 1'b1;
      for (int i = 0; i < 5; i++) begin
         tick();
         if (i < 4) begin
            exp_c = (sb_q.size() > 0) ? sb_q.pop_front() : 7'h7f;
            exp_v = 1'b0;
         end else begin
            exp_c = 7'h00;
            exp_v = 1'b1;
         end
         checks++;
         if ({vsp, ichar} !== {exp_v, exp_c}) begin
            errors++;
            $display("FAIL display_col%0d: vsp/ichar got %b/%h want %b/%h", i, vsp, ichar, exp_v, exp_c);
         end
      end
      cce = 1'b0;
   endtask

   task automatic test_underrun();
      int n;
      logic bad;
      setup_small(8'h01);
      pulse_frame_end();
      dma_fill(1'b0, 7'h41, n);
      pulse_line_end();
      checks++;
      if ({dreq, underrun} !== 2'b10) begin
         errors++;
         $display("FAIL ur_row0: dreq/underrun got %b%b want 10", dreq, underrun);
      end
      pulse_line_end();
      pulse_line_end();
      checks++;
      if ({underrun, line} !== {1'b1, 4'd0}) begin
         errors++;
         $display("FAIL ur_set: underrun/line got %b/%0d want 1/0", underrun, line);
      end
      bad = 1'b0;
      cce = 1'b1;
      repeat (5) begin
         tick();
         if ({vsp, ichar} !== {1'b1, 7'h0}) bad = 1'b1;
      end
      cce = 1'b0;
      checks++;
      if (bad !== 1'b0) begin
         errors++;
         $display("FAIL ur_row_blank: non-blank char seen got %b want 0", bad);
      end
      checks++;
      if (underrun !== 1'b1) begin
         errors++;
         $display("FAIL ur_sticky: got %b want 1", underrun);
      end
      cfg_write(3'd6, 8'h01);
      checks++;
      if (underrun !== 1'b0) begin
         errors++;
         $display("FAIL ur_clear: got %b want 0", underrun);
      end
   endtask

   task automatic test_cursor();
      int n;
      setup_small(8'h01);
      cfg_write(3'd4, 8'd2);
      cfg_write(3'd5, 8'd0);
      cfg_write(3'd3, 8'd1);
      pulse_frame_end();
      dma_fill(1'b0, 7'h41, n);
      pulse_line_end();
      for (int ln = 0; ln < 2; ln++) begin
         cce = 1'b1;
         for (int i = 0; i < 5; i++) begin
            tick();
            checks++;
            if (lten !== (ln == 1 && i == 2)) begin
               errors++;
               $display("FAIL cursor_l%0d_c%0d: lten got %b want %b", ln, i, lten, (ln == 1 && i == 2));
            end
         end
         cce = 1'b0;
         pulse_line_end();
      end
   endtask

   task automatic test_blink();
      int n, fcnt;
      logic [2:0] seen;
      logic [2:0] want;
      setup_small(8'h05);
      cfg_write(3'd4, 8'd2);
      cfg_write(3'd5, 8'd0);
      cfg_write(3'd3, 8'd1);
      for (int f = 1; f <= 32; f++) begin
         pulse_frame_end();
         fcnt = f % 32;
         if (f == 15 || f == 16 || f == 31 || f == 32) begin
            dma_fill(1'b0, 7'h41, n);
            pulse_line_end();
            pulse_line_end();
            cce = 1'b1;
            for (int i = 0; i < 3; i++) begin
               tick();
               seen[i] = lten;
            end
            cce = 1'b0;
            want = {fcnt < 16, 2'b00};
            checks++;
            if (seen !== want) begin
               errors++;
               $display("FAIL blink_frame%0d: lten cols2..0 got %b want %b", fcnt, seen, want);
            end
         end
      end
      sb_q.delete();
   endtask

   task automatic test_frame_priority();
      int n;
      logic [6:0] exp_c;
      setup_small(8'h01);
      pulse_frame_end();
      dma_fill(1'b0, 7'h41, n);
      pulse_line_end();
      dma_fill(1'b0, 7'h51, n);
      pulse_line_end();
      checks++;
      if ({dreq, line} !== {1'b0, 4'd1}) begin
         errors++;
         $display("FAIL prio_before: dreq/line got %b/%0d want 0/1", dreq, line);
      end
      frame_end = 1'b1; line_end = 1'b1;
      tick();
      frame_end = 1'b0; line_end = 1'b0;
      checks++;
      if ({frame_irq, dreq, line, underrun} !== {1'b1, 1'b1, 4'd0, 1'b0}) begin
         errors++;
         $display("FAIL prio_edge: irq/dreq/line/ur got %b/%b/%0d/%b want 1/1/0/0", frame_irq, dreq, line, underrun);
      end
      cce = 1'b1; tick(); cce = 1'b0;
      checks++;
      if ({frame_irq, vsp} !== 2'b01) begin
         errors++;
         $display("FAIL prio_prime: irq/vsp got %b%b want 01", frame_irq, vsp);
      end
      sb_q.delete();
      dma_fill(1'b0, 7'h61, n);
      pulse_line_end();
      cce = 1'b1;
      for (int i = 0; i < 4; i++) begin
         tick();
         exp_c = (sb_q.size() > 0) ? sb_q.pop_front() : 7'h7f;
         checks++;
         if ({vsp, ichar} !== {1'b0, exp_c}) begin
            errors++;
            $display("FAIL prio_row0_col%0d: vsp/ichar got %b/%h want 0/%h", i, vsp, ichar, exp_c);
         end
      end
      cce = 1'b0;
   endtask

   initial begin
      test_reset();
      test_default_dims();
      test_fill_display(1'b0, 7'h41);
      test_fill_display(1'b1, 7'h31);
      test_underrun();
      test_cursor();
      test_blink();
      test_frame_priority();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/rk_crt_ctrl.md
Name: rk_crt_ctrl

Overview:
- Row-sequencing CRT controller. It is a simplified 8275-style scheduler that drives the character-video block.
- Fetches each character row over a DMA request/acknowledge handshake into one of two row buffers, while the other buffer is displayed.
- On every character clock enable it presents ichar/line/vsp/lten/rvv.
- Sits between the DMA engine, the CPU config bus and the video output block.

Parameters:
- MAX_COLS, 80, row buffer depth per bank; chars-per-row config is clamped to MAX_COLS-1.
- BLINK_BIT, 4, frame-counter bit used for cursor blink (low = visible).

Ports:
- clk50mhz  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- cfg_we  in  1  config write strobe
- cfg_addr  in  3  register select
- cfg_data  in  8  write data
- cce  in  1  character clock enable from the video block
- line_end  in  1  one-clk pulse at end of each scan line
- frame_end  in  1  one-clk pulse at start of vertical blanking
- dreq  out  1  DMA request
- dack  in  1  DMA acknowledge; one byte per clk when dreq&dack
- ddata  in  8  DMA data; bit 7 ignored
- ichar  out  7  current character code
- line  out  4  scan line within row
- vsp  out  1  blank video
- lten  out  1  cursor underline enable
- rvv  out  1  reverse video
- frame_irq  out  1  one-clk pulse on frame_end
- underrun  out  1  sticky: row not filled at swap time; cleared by ctrl write

Behaviour:
- Config registers, written on cfg_we:
  - 0: cpr = chars/row-1 [6:0], clamped to MAX_COLS-1.
  - 1: rps = rows-1 [5:0].
  - 2: lpr = lines/row-1 [3:0].
  - 3: ul = underline line [3:0].
  - 4: cursor col [6:0].
  - 5: cursor row [5:0].
  - 6: ctrl: bit0 display enable, bit1 reverse, bit2 blink enable. Any write to reg 6 clears underrun.
  - Addresses 7: ignored.
- Reset defaults: cpr=77, rps=29, lpr=9, ul=9, cursor=(0,0), ctrl=0.
- Output reset values: ichar=0, line=0, vsp=1, lten=0, rvv=0, dreq=0, frame_irq=0, underrun=0. Both FSMs idle; frame counter 0.
- Fetch FSM:
  - F_IDLE: a start command sets fill bank and count=0, then moves to F_FILL.
  - F_FILL: dreq=1. Each clk with dack writes ddata[6:0] to buf[bank][count] and increments count. On the write with count==cpr, dreq drops the same clk edge (registered: dreq low from the next clk). No extra request is issued. Moves to F_DONE.
  - F_DONE: holds until the next start command.
  - A start command arriving in F_FILL restarts the fill (count=0).
- Display FSM:
  - Any state, frame_end: row=0, line=0, frame counter +1, frame_irq pulses. If display enabled: start fill of row 0 into bank 0, go D_PRIME; else go D_END.
  - D_PRIME: on line_end with fetch in F_DONE, disp bank=0, line=0. If rps>0 start fill of bank 1, else no fill is started. Go D_ACTIVE. If fetch is not done on line_end, stay in D_PRIME.
  - D_ACTIVE, line_end, line<lpr: line+1.
  - D_ACTIVE, line_end, line==lpr, row==rps: go D_END.
  - D_ACTIVE, line_end, line==lpr, otherwise: row+1, line=0. If fetch is done: toggle disp bank and, if row+1<rps, start the next fill into the freed bank. If fetch is not done: set underrun, blank the whole row, do not toggle, and restart the fill into the same target bank.
  - D_END: idle until frame_end.
  - Every line_end resets col=0.
- Per cce:
  - ichar <= buf[disp][col]; col increments, saturating at cpr+1. Outputs are valid 1 clk after cce.
  - vsp=1 when: state!=D_ACTIVE, display disabled, col>cpr, or underrun row. When vsp=1, ichar=0.
  - lten=1 when: col==cursor col, row==cursor row, line==ul, D_ACTIVE, and (blink disabled or frame counter[BLINK_BIT]==0).
  - rvv = ctrl bit1, registered on cce.
- Simultaneous events:
  - frame_end has priority over line_end.
  - cfg writes take effect the next clk; cpr changes mid-fill apply to the end test immediately.
- Reset mid-fill: dreq drops asynchronously; buffer contents undefined.

Decomposition:
- Package rk_crt_pkg holds:
  - register address constants;
  - fetch and display state encodings;
  - MAX_COLS and reset-default constants.
- Sub-module rk_row_buffer: 2 x MAX_COLS x 7 dual-port RAM; write port for DMA, read port for display.

Test Plan:
- Reset asserted mid-frame -> dreq=0, vsp=1, ichar=0, lten=0, underrun=0 while reset high; cfg regs read back defaults via behaviour (78 cols, 30 rows).
- Write cpr=3, rps=1, lpr=1, ctrl=1; frame_end; dack held 1 with ddata 0x41..0x44 -> exactly 4 transfers, dreq low after 4th; next line_end enters D_ACTIVE; cce stream gives ichar 0x41,0x42,0x43,0x44 with vsp=0, then 5th cce vsp=1, ichar=0.
- Same setup, dack toggling every other clk -> still exactly 4 writes, correct order; dreq never high after count reached.
- Hold dack=0 through end of row 0 -> at row 0 line 1 line_end, underrun=1, row 1 fully vsp=1; write ctrl -> underrun=0.
- Cursor (2,0), ul=1, blink off -> lten=1 only on cce for col 2, line 1, row 0. Blink on -> lten=1 in frames 0-15, 0 in frames 16-31.
- frame_end coincident with line_end in D_ACTIVE -> row=0, line=0, state D_PRIME, frame_irq one clk, dreq asserted next clk.
